shift_rotate_engine: RTL

//  Parametrised multi-cycle shift/rotate engine for the bit-serial adder datapath.

---
 rtl/coa_shift_pkg.sv | 18 +
 rtl/shift_step.sv | 42 ++++
 rtl/shift_rotate_engine.sv | 106 ++++++++++
 3 files changed

// File: rtl/coa_shift_pkg.sv
// Shared constants for the shift/rotate engine: mode and direction codes, FSM states.
package coa_shift_pkg;

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_LOG = 2'b01;
    localparam logic [1:0] MODE_ARI = 2'b10;
    localparam logic [1:0] MODE_SER = 2'b11;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step: produces the shifted operand and the bit that leaves it.
module shift_step
    import coa_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_bit_o
);

    logic fill;

    always_comb begin
        fill      = 1'b0;
        q_o       = q_i;
        out_bit_o = 1'b0;
        if (dir_i == DIR_R) begin
            out_bit_o = q_i[0];
            case (mode_i)
                MODE_ROT: fill = q_i[0];
                MODE_ARI: fill = q_i[WIDTH-1];
                MODE_SER: fill = serial_in_i;
                default:  fill = 1'b0;
            endcase
            q_o = {fill, q_i[WIDTH-1:1]};
        end else begin
            // Left arithmetic shift fills with zero, same as logical.
            out_bit_o = q_i[WIDTH-1];
            case (mode_i)
                MODE_ROT: fill = q_i[WIDTH-1];
                MODE_SER: fill = serial_in_i;
                default:  fill = 1'b0;
            endcase
            q_o = {q_i[WIDTH-2:0], fill};
        end
    end

endmodule

// File: rtl/shift_rotate_engine.sv
// Multi-cycle shift/rotate engine: one single-bit step per clock, amount steps per operation.
//   state   | meaning
//   ST_IDLE | accepts load (priority) or start
//   ST_RUN  | one step per cycle, counter counts down to 1
//   ST_DONE | single cycle with done asserted, back to idle
module shift_rotate_engine
    import coa_shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = $clog2(WIDTH + 1),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] amount_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             serial_out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;

    logic [CNT_W-1:0] amt_clamp;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign amt_clamp = (amount_i > MAX_AMT) ? MAX_AMT : amount_i;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i         (q_q),
        .dir_i       (dir_q),
        .mode_i      (mode_q),
        .serial_in_i (serial_in_i),
        .q_o         (step_q),
        .out_bit_o   (step_out)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    q_d = data_in_i;
                end else if (start_i) begin
                    dir_d   = dir_i;
                    mode_d  = mode_i;
                    cnt_d   = amt_clamp;
                    state_d = (amt_clamp == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                q_d    = step_q;
                sout_d = step_out;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= DIR_R;
            mode_q  <= MODE_ROT;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign q_o          = q_q;
    assign serial_out_o = sout_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

endmodule
